multi_cycle_ctrl: RTL and testbench
===================================

# multi_cycle_ctrl

Multicycle control FSM that sequences the shared ALU and the surrounding datapath: PC, IR, register file, memory port, and operand/write-back muxes. It sits beside the ALU in the multicycle RV32I core. Each cycle it decodes the latched instruction plus the current state into ALU opcode, mux selects and write enables. It uses the ALU `Zero` output to resolve branches.

## Interface
Parameters:
- RESET_STATE, S_IF — state entered on reset.

Ports:
- clk  in  1  rising-edge clock.
- rstn  in  1  reset; asynchronous, active-low.
- instr  in  32  instruction from IR (stable after IF).
- zero  in  1  ALU Zero (1 = compare true).
- mem_ready  in  1  memory completion strobe.
- pc_we  out  1  PC write enable.
- pc_src  out  2  PC source: 0 = PC+4, 1 = OLDPC+imm, 2 = ALU result.
- oldpc_we  out  1  latch current PC into OLDPC.
- ir_we  out  1  IR write enable.
- iord  out  1  memory address select: 0 = PC, 1 = ALU out.
- mem_re, mem_we  out  1 each  memory read/write strobes.
- alu_src_a  out  2  ALU A select: 0 = rs1, 1 = OLDPC, 2 = zero.
- alu_src_b  out  2  ALU B select: 0 = rs2, 1 = imm.
- alu_op  out  5  ALUOP_* code.
- imm_sel  out  3  immediate format: I/S/B/U/J.
- reg_we  out  1  register file write enable.
- wb_sel  out  2  write-back select: 0 = ALU out, 1 = memory data, 2 = OLDPC+4.
- state  out  3  current state, for debug.
- illegal  out  1  one-cycle pulse on an unknown opcode.

## Operation
- States are S_IF, S_ID, S_EX, S_MEM, S_WB.
- **S_IF**
  - Asserts mem_re, iord=0, ir_we, oldpc_we, pc_we with pc_src=0.
  - Next state is S_ID.
- **S_ID**
  - Selects imm_sel from the opcode. No enables are asserted.
  - A known opcode goes to S_EX.
  - An unknown opcode pulses illegal and returns to S_IF; the instruction acts as a NOP.
- **S_EX**
  - R-type: alu_op from funct3/funct7, with SUB and SRA selected by funct7[5]; B=rs2. Next S_WB.
  - I-ALU: alu_op from funct3, B=imm. Next S_WB.
  - Load/store: ALUOP_ADD, rs1+imm. Next S_MEM.
  - LUI: ALUOP_LUI, B=imm. Next S_WB.
  - AUIPC: ALUOP_AUIPC, A=OLDPC, B=imm. Next S_WB.
  - Branch:
    - Compares rs1 against rs2 using ALUOP_BEQ, BNE, BLT, BGE, BLTU or BGEU.
    - If zero=1: pc_we with pc_src=1.
    - Next state is S_IF.
  - JAL: pc_we with pc_src=1. Next S_WB.
  - JALR:
    - Uses ALUOP_JALR with rs1+imm.
    - pc_we with pc_src=2.
    - Next state is S_WB.
- **S_MEM**
  - Load: mem_re, iord=1. Next S_WB.
  - Store: mem_we, iord=1. Next S_IF.
- **S_WB**
  - Asserts reg_we. wb_sel is 1 for loads, 2 for JAL/JALR, 0 otherwise.
  - Next state is S_IF.
- Writes to rd = x0 still assert reg_we; the register file discards them.

## Timing
- State register updates on the clock edge.
- All other outputs are combinational from state and instr, gated low while rstn=0.
- Reset values:
  - All enables and strobes: 0.
  - alu_op = ALUOP_ADD.
  - All selects and illegal: 0.
  - state = S_IF.
- Cycle counts, without wait states:
  - Branch: 3.
  - Store: 4.
  - ALU, LUI, AUIPC, JAL, JALR: 4.
  - Load: 5.
  - Illegal: 2.
- Asserting rstn=0 in any state returns the FSM to S_IF immediately. No partial write occurs after reset assertion. The first fetch happens on the first rising edge after rstn deasserts.
- zero is sampled only in S_EX for branches. PC and IR never write in the same cycle except in S_IF.

## Configuration
- Macro: MEM_WAIT_EN.
- Defined:
  - S_IF and S_MEM hold until mem_ready=1.
  - ir_we, oldpc_we, pc_we (in S_IF) and the state transition occur only in the mem_ready cycle.
  - mem_re/mem_we stay asserted while waiting.
- Undefined:
  - mem_ready is ignored; every memory access completes in one cycle.

## Structure
- The ALUOP_*, state, pc_src, wb_sel and imm_sel encodings go in the shared control-encoding header.
- Opcode and funct3 constants also go in that header.
- Sub-module alu_op_dec: combinational map from opcode/funct3/funct7 to alu_op and imm_sel. The FSM instantiates it once.

## Test plan
- addi x1,x0,5 (0x00500093), MEM_WAIT_EN undefined:
  - states IF→ID→EX→WB.
  - EX: alu_op=ALUOP_ADD, alu_src_b=1.
  - WB: reg_we=1, wb_sel=0.
  - Back in IF on cycle 5.
- lw x2,0(x1), MEM_WAIT_EN defined, mem_ready held low for 3 cycles in S_MEM:
  - FSM stays in S_MEM for 4 cycles with mem_re=1, iord=1.
  - Then WB with wb_sel=1.
- beq x1,x1,+8:
  - zero=1 → pc_we=1, pc_src=1 in EX.
  - zero=0 → pc_we=0.
  - Both cases return to IF after 3 cycles.
- jalr x1,4(x2):
  - EX: alu_op=ALUOP_JALR, pc_we=1, pc_src=2.
  - WB: reg_we=1, wb_sel=2.
- instr=0xFFFFFFFF:
  - illegal=1 for exactly 1 cycle in S_ID.
  - reg_we/mem_we never assert.
  - Next state is S_IF.
- rstn pulsed low during S_MEM of sw:
  - mem_we drops immediately and state=S_IF.
  - No store completes; fetch resumes after release.

Source files
------------

// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared control encodings for the multicycle RV32I core:
// FSM states, ALU opcodes, mux selects, opcode and funct3 constants.
package multi_cycle_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_e;

    typedef enum logic [4:0] {
        ALUOP_ADD   = 5'd0,
        ALUOP_SUB   = 5'd1,
        ALUOP_SLL   = 5'd2,
        ALUOP_SLT   = 5'd3,
        ALUOP_SLTU  = 5'd4,
        ALUOP_XOR   = 5'd5,
        ALUOP_SRL   = 5'd6,
        ALUOP_SRA   = 5'd7,
        ALUOP_OR    = 5'd8,
        ALUOP_AND   = 5'd9,
        ALUOP_LUI   = 5'd10,
        ALUOP_AUIPC = 5'd11,
        ALUOP_BEQ   = 5'd12,
        ALUOP_BNE   = 5'd13,
        ALUOP_BLT   = 5'd14,
        ALUOP_BGE   = 5'd15,
        ALUOP_BLTU  = 5'd16,
        ALUOP_BGEU  = 5'd17,
        ALUOP_JALR  = 5'd18
    } aluop_e;

    typedef enum logic [3:0] {
        CLS_ILL   = 4'd0,
        CLS_R     = 4'd1,
        CLS_I     = 4'd2,
        CLS_LD    = 4'd3,
        CLS_ST    = 4'd4,
        CLS_LUI   = 4'd5,
        CLS_AUIPC = 4'd6,
        CLS_BR    = 4'd7,
        CLS_JAL   = 4'd8,
        CLS_JALR  = 4'd9
    } iclass_e;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_ALU    = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic [1:0] SRCA_RS1   = 2'd0;
    localparam logic [1:0] SRCA_OLDPC = 2'd1;
    localparam logic [1:0] SRCA_ZERO  = 2'd2;

    localparam logic [1:0] SRCB_RS2 = 2'd0;
    localparam logic [1:0] SRCB_IMM = 2'd1;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // alt is funct7[5]; it selects SUB only for register-register ops
    function automatic aluop_e arith_op(
        input logic [2:0] f3,
        input logic       alt,
        input logic       is_reg
    );
        aluop_e op;
        unique case (f3)
            F3_ADD:  op = (alt && is_reg) ? ALUOP_SUB : ALUOP_ADD;
            F3_SLL:  op = ALUOP_SLL;
            F3_SLT:  op = ALUOP_SLT;
            F3_SLTU: op = ALUOP_SLTU;
            F3_XOR:  op = ALUOP_XOR;
            F3_SR:   op = alt ? ALUOP_SRA : ALUOP_SRL;
            F3_OR:   op = ALUOP_OR;
            F3_AND:  op = ALUOP_AND;
            default: op = ALUOP_ADD;
        endcase
        return op;
    endfunction

    function automatic aluop_e branch_op(input logic [2:0] f3);
        aluop_e op;
        unique case (f3)
            F3_BNE:  op = ALUOP_BNE;
            F3_BLT:  op = ALUOP_BLT;
            F3_BGE:  op = ALUOP_BGE;
            F3_BLTU: op = ALUOP_BLTU;
            F3_BGEU: op = ALUOP_BGEU;
            default: op = ALUOP_BEQ;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/multi_cycle_ctrl_alu_op_dec.sv
// Instruction decoder: opcode/funct3/funct7 to instruction class,
// ALU opcode and immediate format.
module alu_op_dec
    import multi_cycle_ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    output aluop_e     alu_op_o,
    output logic [2:0] imm_sel_o,
    output iclass_e    cls_o
);

    logic unused_funct7;
    assign unused_funct7 = ^{funct7_i[6], funct7_i[4:0]};

    always_comb begin
        cls_o     = CLS_ILL;
        imm_sel_o = IMM_I;
        alu_op_o  = ALUOP_ADD;
        unique case (opcode_i)
            OPC_OP: begin
                cls_o    = CLS_R;
                alu_op_o = arith_op(funct3_i, funct7_i[5], 1'b1);
            end
            OPC_OP_IMM: begin
                cls_o    = CLS_I;
                alu_op_o = arith_op(funct3_i, funct7_i[5], 1'b0);
            end
            OPC_LOAD: begin
                cls_o = CLS_LD;
            end
            OPC_STORE: begin
                cls_o     = CLS_ST;
                imm_sel_o = IMM_S;
            end
            OPC_LUI: begin
                cls_o     = CLS_LUI;
                imm_sel_o = IMM_U;
                alu_op_o  = ALUOP_LUI;
            end
            OPC_AUIPC: begin
                cls_o     = CLS_AUIPC;
                imm_sel_o = IMM_U;
                alu_op_o  = ALUOP_AUIPC;
            end
            OPC_BRANCH: begin
                cls_o     = CLS_BR;
                imm_sel_o = IMM_B;
                alu_op_o  = branch_op(funct3_i);
            end
            OPC_JAL: begin
                cls_o     = CLS_JAL;
                imm_sel_o = IMM_J;
            end
            OPC_JALR: begin
                cls_o    = CLS_JALR;
                alu_op_o = ALUOP_JALR;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multicycle RV32I control FSM (IF/ID/EX/MEM/WB) driving the shared ALU.
// Define MEM_WAIT_EN to stall IF and MEM until mem_ready.
module multi_cycle_ctrl
    import multi_cycle_ctrl_pkg::*;
#(
    parameter state_e RESET_STATE = S_IF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        oldpc_we,
    output logic        ir_we,
    output logic        iord,
    output logic        mem_re,
    output logic        mem_we,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [4:0]  alu_op,
    output logic [2:0]  imm_sel,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic [2:0]  state,
    output logic        illegal
);

    state_e     state_q, state_d;
    aluop_e     dec_op;
    logic [2:0] dec_imm;
    iclass_e    dec_cls;
    logic       mem_done;

`ifdef MEM_WAIT_EN
    assign mem_done = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_done = 1'b1;
`endif

    logic unused_instr;
    assign unused_instr = ^{instr[24:15], instr[11:7]};

    alu_op_dec u_dec (
        .opcode_i  (instr[6:0]),
        .funct3_i  (instr[14:12]),
        .funct7_i  (instr[31:25]),
        .alu_op_o  (dec_op),
        .imm_sel_o (dec_imm),
        .cls_o     (dec_cls)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IF: begin
                if (mem_done) state_d = S_ID;
            end
            S_ID: begin
                state_d = (dec_cls == CLS_ILL) ? S_IF : S_EX;
            end
            S_EX: begin
                unique case (dec_cls)
                    CLS_LD, CLS_ST: state_d = S_MEM;
                    CLS_BR, CLS_ILL: state_d = S_IF;
                    default:         state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (mem_done) begin
                    state_d = (dec_cls == CLS_LD) ? S_WB : S_IF;
                end
            end
            S_WB:    state_d = S_IF;
            default: state_d = S_IF;
        endcase
    end

    assign state = state_q;

    // All outputs sit at their idle values while reset is held
    always_comb begin
        pc_we     = 1'b0;
        pc_src    = PC_PLUS4;
        oldpc_we  = 1'b0;
        ir_we     = 1'b0;
        iord      = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALUOP_ADD;
        imm_sel   = IMM_I;
        reg_we    = 1'b0;
        wb_sel    = WB_ALU;
        illegal   = 1'b0;
        if (rstn) begin
            unique case (state_q)
                S_IF: begin
                    mem_re   = 1'b1;
                    ir_we    = mem_done;
                    oldpc_we = mem_done;
                    pc_we    = mem_done;
                end
                S_ID: begin
                    imm_sel = dec_imm;
                    illegal = (dec_cls == CLS_ILL);
                end
                S_EX: begin
                    imm_sel = dec_imm;
                    alu_op  = dec_op;
                    unique case (dec_cls)
                        CLS_I, CLS_LD, CLS_ST: begin
                            alu_src_b = SRCB_IMM;
                        end
                        CLS_LUI: begin
                            alu_src_a = SRCA_ZERO;
                            alu_src_b = SRCB_IMM;
                        end
                        CLS_AUIPC: begin
                            alu_src_a = SRCA_OLDPC;
                            alu_src_b = SRCB_IMM;
                        end
                        CLS_BR: begin
                            pc_src = PC_BRANCH;
                            pc_we  = zero;
                        end
                        CLS_JAL: begin
                            pc_src = PC_BRANCH;
                            pc_we  = 1'b1;
                        end
                        CLS_JALR: begin
                            alu_src_b = SRCB_IMM;
                            pc_src    = PC_ALU;
                            pc_we     = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    imm_sel = dec_imm;
                    iord    = 1'b1;
                    mem_re  = (dec_cls == CLS_LD);
                    mem_we  = (dec_cls == CLS_ST);
                end
                S_WB: begin
                    imm_sel = dec_imm;
                    reg_we  = 1'b1;
                    unique case (dec_cls)
                        CLS_LD:           wb_sel = WB_MEM;
                        CLS_JAL, CLS_JALR: wb_sel = WB_PC4;
                        default:          wb_sel = WB_ALU;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard bench for multi_cycle_ctrl: directed cases plus random
// instruction stream checked against a per-instruction phase model.
module tb_multi_cycle_ctrl;
    import multi_cycle_ctrl_pkg::*;

`ifdef MEM_WAIT_EN
    localparam bit WAIT = 1'b1;
`else
    localparam bit WAIT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] instr;
    logic        zero;
    logic        mem_ready;
    logic        pc_we, oldpc_we, ir_we, iord, mem_re, mem_we;
    logic        reg_we, illegal;
    logic [1:0]  pc_src, alu_src_a, alu_src_b, wb_sel;
    logic [4:0]  alu_op;
    logic [2:0]  imm_sel, state;

    always #5 clk = ~clk;

    multi_cycle_ctrl dut (
        .clk       (clk),
        .rstn      (rstn),
        .instr     (instr),
        .zero      (zero),
        .mem_ready (mem_ready),
        .pc_we     (pc_we),
        .pc_src    (pc_src),
        .oldpc_we  (oldpc_we),
        .ir_we     (ir_we),
        .iord      (iord),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .alu_op    (alu_op),
        .imm_sel   (imm_sel),
        .reg_we    (reg_we),
        .wb_sel    (wb_sel),
        .state     (state),
        .illegal   (illegal)
    );

    typedef struct packed {
        logic [2:0] st;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       oldpc_we;
        logic       ir_we;
        logic       iord;
        logic       mem_re;
        logic       mem_we;
        logic [1:0] a;
        logic [1:0] b;
        logic [4:0] op;
        logic [2:0] imm;
        logic       reg_we;
        logic [1:0] wb;
        logic       ill;
    } obs_t;

    typedef struct {
        logic [31:0] base;
        logic [31:0] mask;
        iclass_e     cls;
        aluop_e      op;
        logic [2:0]  imm;
    } ent_t;

    ent_t tbl[$];
    obs_t sb[$];
    int   total = 0;
    int   bad = 0;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            obs_t w;
            obs_t g;
            w = sb.pop_front();
            g = {state, pc_we, pc_src, oldpc_we, ir_we, iord, mem_re,
                 mem_we, alu_src_a, alu_src_b, alu_op, imm_sel, reg_we,
                 wb_sel, illegal};
            total++;
            if (g !== w) begin
                bad++;
                $display("FAIL ctrl t=%0t instr=%h got=%h want=%h",
                         $time, instr, g, w);
            end
        end
    end

    function automatic obs_t idle();
        obs_t e;
        e    = '0;
        e.st = S_IF;
        e.op = ALUOP_ADD;
        return e;
    endfunction

    function automatic bit known(input logic [6:0] o);
        return o inside {OPC_LOAD, OPC_STORE, OPC_OP, OPC_OP_IMM, OPC_LUI,
                         OPC_AUIPC, OPC_BRANCH, OPC_JAL, OPC_JALR};
    endfunction

    task automatic add(input logic [31:0] base, input logic [31:0] mask,
                       input iclass_e c, input aluop_e op,
                       input logic [2:0] im);
        ent_t t;
        t.base = base;
        t.mask = mask;
        t.cls  = c;
        t.op   = op;
        t.imm  = im;
        tbl.push_back(t);
    endtask

    task automatic cyc(input obs_t e);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // zsel: 0/1 forces zero in EX, 2 randomizes; mwait<0 randomizes
    task automatic run(input logic [31:0] ins, input iclass_e c,
                       input aluop_e op, input logic [2:0] im,
                       input int zsel, input int mwait, input bit rst_mem);
        obs_t e;
        bit   fire;
        int   n;
        logic z;
        instr = ins;
        do begin
            mem_ready  = WAIT ? ($urandom_range(2) == 0) : 1'($urandom);
            zero       = 1'($urandom);
            fire       = !WAIT || mem_ready;
            e          = idle();
            e.mem_re   = 1'b1;
            e.ir_we    = fire;
            e.oldpc_we = fire;
            e.pc_we    = fire;
            cyc(e);
        end while (!fire);
        mem_ready = 1'($urandom);
        zero      = 1'($urandom);
        e         = idle();
        e.st      = S_ID;
        e.imm     = im;
        e.ill     = (c == CLS_ILL);
        cyc(e);
        if (c == CLS_ILL) return;
        z     = (zsel == 2) ? 1'($urandom) : 1'(zsel);
        zero  = z;
        e     = idle();
        e.st  = S_EX;
        e.imm = im;
        e.op  = op;
        case (c)
            CLS_I, CLS_LD, CLS_ST: e.b = SRCB_IMM;
            CLS_LUI:   begin e.a = SRCA_ZERO;  e.b = SRCB_IMM; end
            CLS_AUIPC: begin e.a = SRCA_OLDPC; e.b = SRCB_IMM; end
            CLS_BR:    begin e.pc_src = PC_BRANCH; e.pc_we = z; end
            CLS_JAL:   begin e.pc_src = PC_BRANCH; e.pc_we = 1'b1; end
            CLS_JALR: begin
                e.b = SRCB_IMM; e.pc_src = PC_ALU; e.pc_we = 1'b1;
            end
            default: ;
        endcase
        cyc(e);
        if (c == CLS_BR) return;
        if (c == CLS_LD || c == CLS_ST) begin
            if (rst_mem) begin
                rstn = 1'b0;
                cyc(idle());
                cyc(idle());
                rstn = 1'b1;
                return;
            end
            n = 0;
            do begin
                if (mwait >= 0) mem_ready = (n >= mwait);
                else mem_ready = WAIT ? ($urandom_range(1) == 0)
                                      : 1'($urandom);
                zero     = 1'($urandom);
                fire     = !WAIT || mem_ready;
                e        = idle();
                e.st     = S_MEM;
                e.imm    = im;
                e.iord   = 1'b1;
                e.mem_re = (c == CLS_LD);
                e.mem_we = (c == CLS_ST);
                cyc(e);
                n++;
            end while (!fire);
            if (c == CLS_ST) return;
        end
        zero     = 1'($urandom);
        e        = idle();
        e.st     = S_WB;
        e.imm    = im;
        e.reg_we = 1'b1;
        if (c == CLS_LD) e.wb = WB_MEM;
        else if (c == CLS_JAL || c == CLS_JALR) e.wb = WB_PC4;
        else e.wb = WB_ALU;
        cyc(e);
    endtask

    initial begin
        logic [31:0] w;
        int          k;
        ent_t        t;
        rstn      = 1'b0;
        instr     = '0;
        zero      = 1'b0;
        mem_ready = 1'b0;

        add(32'h00000033, 32'h01FF8F80, CLS_R, ALUOP_ADD,  IMM_I);
        add(32'h40000033, 32'h01FF8F80, CLS_R, ALUOP_SUB,  IMM_I);
        add(32'h00001033, 32'h01FF8F80, CLS_R, ALUOP_SLL,  IMM_I);
        add(32'h00002033, 32'h01FF8F80, CLS_R, ALUOP_SLT,  IMM_I);
        add(32'h00003033, 32'h01FF8F80, CLS_R, ALUOP_SLTU, IMM_I);
        add(32'h00004033, 32'h01FF8F80, CLS_R, ALUOP_XOR,  IMM_I);
        add(32'h00005033, 32'h01FF8F80, CLS_R, ALUOP_SRL,  IMM_I);
        add(32'h40005033, 32'h01FF8F80, CLS_R, ALUOP_SRA,  IMM_I);
        add(32'h00006033, 32'h01FF8F80, CLS_R, ALUOP_OR,   IMM_I);
        add(32'h00007033, 32'h01FF8F80, CLS_R, ALUOP_AND,  IMM_I);
        add(32'h00000013, 32'hFFFF8F80, CLS_I, ALUOP_ADD,  IMM_I);
        add(32'h00002013, 32'hFFFF8F80, CLS_I, ALUOP_SLT,  IMM_I);
        add(32'h00003013, 32'hFFFF8F80, CLS_I, ALUOP_SLTU, IMM_I);
        add(32'h00004013, 32'hFFFF8F80, CLS_I, ALUOP_XOR,  IMM_I);
        add(32'h00006013, 32'hFFFF8F80, CLS_I, ALUOP_OR,   IMM_I);
        add(32'h00007013, 32'hFFFF8F80, CLS_I, ALUOP_AND,  IMM_I);
        add(32'h00001013, 32'h01FF8F80, CLS_I, ALUOP_SLL,  IMM_I);
        add(32'h00005013, 32'h01FF8F80, CLS_I, ALUOP_SRL,  IMM_I);
        add(32'h40005013, 32'h01FF8F80, CLS_I, ALUOP_SRA,  IMM_I);
        add(32'h00000003, 32'hFFFFFF80, CLS_LD, ALUOP_ADD, IMM_I);
        add(32'h00000023, 32'hFFFFFF80, CLS_ST, ALUOP_ADD, IMM_S);
        add(32'h00000037, 32'hFFFFFF80, CLS_LUI, ALUOP_LUI, IMM_U);
        add(32'h00000017, 32'hFFFFFF80, CLS_AUIPC, ALUOP_AUIPC, IMM_U);
        add(32'h0000006F, 32'hFFFFFF80, CLS_JAL, ALUOP_ADD, IMM_J);
        add(32'h00000067, 32'hFFFF8F80, CLS_JALR, ALUOP_JALR, IMM_I);
        add(32'h00000063, 32'hFFFF8F80, CLS_BR, ALUOP_BEQ,  IMM_B);
        add(32'h00001063, 32'hFFFF8F80, CLS_BR, ALUOP_BNE,  IMM_B);
        add(32'h00004063, 32'hFFFF8F80, CLS_BR, ALUOP_BLT,  IMM_B);
        add(32'h00005063, 32'hFFFF8F80, CLS_BR, ALUOP_BGE,  IMM_B);
        add(32'h00006063, 32'hFFFF8F80, CLS_BR, ALUOP_BLTU, IMM_B);
        add(32'h00007063, 32'hFFFF8F80, CLS_BR, ALUOP_BGEU, IMM_B);

        @(posedge clk);
        #1;
        repeat (2) begin
            instr     = $urandom;
            zero      = 1'($urandom);
            mem_ready = 1'($urandom);
            cyc(idle());
        end
        rstn = 1'b1;

        run(32'h00500093, CLS_I,    ALUOP_ADD,  IMM_I, 2, -1, 1'b0);
        run(32'h0000A103, CLS_LD,   ALUOP_ADD,  IMM_I, 2,  3, 1'b0);
        run(32'h00108463, CLS_BR,   ALUOP_BEQ,  IMM_B, 1, -1, 1'b0);
        run(32'h00108463, CLS_BR,   ALUOP_BEQ,  IMM_B, 0, -1, 1'b0);
        run(32'h004100E7, CLS_JALR, ALUOP_JALR, IMM_I, 2, -1, 1'b0);
        run(32'hFFFFFFFF, CLS_ILL,  ALUOP_ADD,  IMM_I, 2, -1, 1'b0);
        run(32'h0020A023, CLS_ST,   ALUOP_ADD,  IMM_S, 2, -1, 1'b1);
        run(32'h0020A023, CLS_ST,   ALUOP_ADD,  IMM_S, 2, -1, 1'b0);

        repeat (400) begin
            k = $urandom_range(tbl.size() + 4);
            if (k < tbl.size()) begin
                t = tbl[k];
                w = t.base | (32'($urandom) & t.mask);
                run(w, t.cls, t.op, t.imm, 2, -1, 1'b0);
            end else begin
                w = $urandom;
                while (known(w[6:0])) w = $urandom;
                run(w, CLS_ILL, ALUOP_ADD, IMM_I, 2, -1, 1'b0);
            end
        end

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
